sequence_detector: RTL and testbench
====================================

SEQUENCE_DETECTOR -- requirements
Module: SequenceDetector

Interface
REQ-001 Parameter LEN, default 3, SHALL be the pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 3'b101, LEN bits wide, SHALL be the target sequence; PATTERN[LEN-1] is the first bit expected.
REQ-003 Parameter OVERLAP, default 1, SHALL select overlapping (1) or non-overlapping (0) matching.
REQ-004 Parameter COUNT_W, default 8, SHALL be the matchCount width, legal range 1..32.
REQ-005 clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 rst, input, 1 bit: synchronous, active-high reset.
REQ-007 clear, input, 1 bit: synchronous restart of the detector and the counter.
REQ-008 valid, input, 1 bit: in is sampled only in cycles where valid=1.
REQ-009 in, input, 1 bit: serial data bit.
REQ-010 out, output, 1 bit: Moore match flag.
REQ-011 matchCount, output, COUNT_W bits: saturating count of completed matches.

Function
REQ-012 The FSM SHALL have states S0..S<LEN>; state Sk means the longest pattern prefix matched so far has length k.
REQ-013 out SHALL equal 1 exactly when state = S<LEN>, and SHALL depend on state only (Moore).
REQ-014 From Sk (k<LEN) on a valid bit b, next state SHALL be the longest pattern prefix that is a suffix of prefix_k followed by b (KMP transition).
REQ-015 From S<LEN> with OVERLAP=1, the transition SHALL be as in REQ-014 with k=LEN; with OVERLAP=0 it SHALL be the transition from S0 on b.
REQ-016 in values other than 1 (0, X, Z) SHALL be treated as 0.
REQ-017 With valid=0, state, out and matchCount SHALL hold.
REQ-018 out SHALL rise in the cycle after the clock edge that samples the last pattern bit (1-cycle latency), and SHALL stay high while valid=0.
REQ-019 matchCount SHALL increment by 1 on each transition into S<LEN>, including S<LEN>->S<LEN>, and SHALL saturate at 2^COUNT_W-1.
REQ-020 clear=1 SHALL force state S0 and matchCount 0 on the next edge, with priority over valid; a bit presented with clear=1 SHALL be discarded.
REQ-021 Any unreachable state encoding SHALL return to S0 on the next edge with out=0.

Reset
REQ-022 rst=1 SHALL set state=S0, out=0 and matchCount=0 on the next rising clk edge, with priority over clear and valid.
REQ-023 rst asserted mid-pattern SHALL discard any partial match; detection restarts from S0.

Configuration
REQ-024 With macro SEQDET_COUNT_EN defined, the match counter SHALL be built and behave per REQ-019/020.
REQ-025 With SEQDET_COUNT_EN undefined, the counter logic SHALL NOT be built and matchCount SHALL be driven constant 0; all other behaviour is unchanged.

Structure
REQ-026 A package SequenceDetectorPkg SHALL hold the elaboration-time KMP next-state function and the LEN/COUNT_W legal-range constants.
REQ-027 The saturating counter SHALL be a sub-module, MatchCounter (inc, clear, count, parameter WIDTH).
REQ-028 Parameters out of range SHALL cause an elaboration-time error.

Verification
REQ-029 LEN=3, PATTERN=101, OVERLAP=1; valid=1, in=1,0,1,0,1 -> out=1 in the cycles after the 3rd and 5th bits; matchCount=2.
REQ-030 Same stream with OVERLAP=0 -> out=1 only after the 3rd bit; matchCount=1.
REQ-031 PATTERN=101; in=1,0, then valid=0 for 4 cycles, then in=1 -> state held across the gap; out=1 after the final bit; matchCount=1.
REQ-032 COUNT_W=2, PATTERN=11, OVERLAP=1; in=1 for 6 cycles -> out stays 1 from the cycle after the 2nd bit; matchCount saturates at 3.
REQ-033 in=1,0, then rst=1 for one cycle, then in=1 -> out=0; the next 1,0,1 -> out=1 after its last bit.
REQ-034 in=1,0 with clear=1 on the cycle presenting the final 1 -> out=0 and matchCount=0; in=X on every sample -> out stays 0.

Source files
------------

// File: rtl/sequence_detector_pkg.sv
// Shared constants, state encoding and the elaboration-time KMP next-state
// function for the serial pattern detector.
package sequence_detector_pkg;

    localparam int LEN_MIN     = 2;
    localparam int LEN_MAX     = 16;
    localparam int COUNT_W_MIN = 1;
    localparam int COUNT_W_MAX = 32;
    localparam int ST_W        = 5;

    typedef enum logic [ST_W-1:0] {
        S0  = 5'd0,  S1  = 5'd1,  S2  = 5'd2,  S3  = 5'd3,
        S4  = 5'd4,  S5  = 5'd5,  S6  = 5'd6,  S7  = 5'd7,
        S8  = 5'd8,  S9  = 5'd9,  S10 = 5'd10, S11 = 5'd11,
        S12 = 5'd12, S13 = 5'd13, S14 = 5'd14, S15 = 5'd15,
        S16 = 5'd16
    } state_e;

    // Longest pattern prefix that is a suffix of (prefix_k . b); pat[len-1] is
    // the first pattern bit. The descending search makes the first hit the longest.
    function automatic int kmp_next(int len, logic [15:0] pat, int k, logic b);
        int  best;
        int  top;
        int  si;
        logic ok;
        logic sb;
        best = 0;
        top  = (k + 1 < len) ? k + 1 : len;
        for (int j = top; j >= 1; j--) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
                si = k + 1 - j + t;
                sb = (si == k) ? b : pat[len-1-si];
                if (sb != pat[len-1-t]) ok = 1'b0;
            end
            if (ok && best == 0) best = j;
        end
        return best;
    endfunction

endpackage

// File: rtl/sequence_detector_match_counter.sv
// Saturating match counter: reset and clear zero it, inc adds one until all ones.
module sequence_detector_match_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (inc && count_q != {WIDTH{1'b1}})
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/sequence_detector.sv
// Moore serial pattern detector using a KMP transition table built at elaboration.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise matchCount is 0.
module sequence_detector
    import sequence_detector_pkg::*;
#(
    parameter int             LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = 3'b101,
    parameter int             OVERLAP = 1,
    parameter int             COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               valid,
    input  logic               in,
    output logic               out,
    output logic [COUNT_W-1:0] matchCount
);

    if (LEN < LEN_MIN || LEN > LEN_MAX) begin : g_bad_len
        $error("sequence_detector: LEN out of range 2..16");
    end
    if (COUNT_W < COUNT_W_MIN || COUNT_W > COUNT_W_MAX) begin : g_bad_cw
        $error("sequence_detector: COUNT_W out of range 1..32");
    end

    // Full 32-entry table so any 5-bit state indexes it; entries past S<LEN> are S0.
    logic [ST_W-1:0] nxt_tbl [32][2];

    for (genvar k = 0; k < 32; k++) begin : g_tbl
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int SRC = (k > LEN || (k == LEN && OVERLAP == 0)) ? 0 : k;
            localparam int NXT = (k <= LEN) ? kmp_next(LEN, 16'(PATTERN), SRC, (b != 0)) : 0;
            assign nxt_tbl[k][b] = ST_W'(NXT);
        end
    end

    state_e state_q, state_d;
    logic   out_q, out_d;
    logic   bit_b;
    logic   legal;

    always_comb begin
        bit_b   = (in === 1'b1);
        legal   = (state_q <= ST_W'(LEN));
        state_d = state_q;
        if (!legal || clear)
            state_d = S0;
        else if (valid)
            state_d = state_e'(nxt_tbl[state_q][bit_b]);
        out_d = (state_d == ST_W'(LEN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

`ifdef SEQDET_COUNT_EN
    logic cnt_inc;
    assign cnt_inc = legal && !clear && valid && (state_d == ST_W'(LEN));

    sequence_detector_match_counter #(
        .WIDTH (COUNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (cnt_inc),
        .count (matchCount)
    );
`else
    assign matchCount = '0;
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// Bench: four detector configurations share one stimulus stream and are
// compared every cycle against a history-based reference model.
module tb_sequence_detector;

    logic clk = 1'b0;
    logic rst = 1'b1, clear = 1'b0, valid = 1'b0, in = 1'b0;
    always #5 clk = ~clk;

    logic       out_a, out_b, out_c, out_d;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [2:0] cnt_d;

    sequence_detector #(.LEN(3), .PATTERN(3'b101), .OVERLAP(1), .COUNT_W(8)) u_a (
        .clk(clk), .rst(rst), .clear(clear), .valid(valid), .in(in), .out(out_a), .matchCount(cnt_a));
    sequence_detector #(.LEN(3), .PATTERN(3'b101), .OVERLAP(0), .COUNT_W(8)) u_b (
        .clk(clk), .rst(rst), .clear(clear), .valid(valid), .in(in), .out(out_b), .matchCount(cnt_b));
    sequence_detector #(.LEN(2), .PATTERN(2'b11), .OVERLAP(1), .COUNT_W(2)) u_c (
        .clk(clk), .rst(rst), .clear(clear), .valid(valid), .in(in), .out(out_c), .matchCount(cnt_c));
    sequence_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(0), .COUNT_W(3)) u_d (
        .clk(clk), .rst(rst), .clear(clear), .valid(valid), .in(in), .out(out_d), .matchCount(cnt_d));

`ifdef SEQDET_COUNT_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    int lens [4] = '{3, 3, 2, 4};
    int pats [4] = '{5, 5, 3, 13};
    int ovs  [4] = '{1, 0, 1, 0};
    int cmax [4] = '{255, 255, 3, 7};

    // Model: bits seen since the last restart; a match is "last LEN bits == pattern".
    int hlen [4];
    int hist [4];
    int mout [4];
    int mcnt [4];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit c, input bit v, input bit b);
        for (int i = 0; i < 4; i++) begin
            if (r || c) begin
                hlen[i] = 0; hist[i] = 0; mout[i] = 0; mcnt[i] = 0;
            end else if (v) begin
                if (ovs[i] == 0 && mout[i] != 0) hlen[i] = 0;
                hist[i] = (hist[i] << 1) | int'(b);
                if (hlen[i] < 32) hlen[i]++;
                mout[i] = (hlen[i] >= lens[i] &&
                           (hist[i] & ((1 << lens[i]) - 1)) == pats[i]) ? 1 : 0;
                if (mout[i] != 0 && mcnt[i] < cmax[i]) mcnt[i]++;
            end
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, "_out_a"}, int'(out_a), mout[0]);
        chk({tag, "_out_b"}, int'(out_b), mout[1]);
        chk({tag, "_out_c"}, int'(out_c), mout[2]);
        chk({tag, "_out_d"}, int'(out_d), mout[3]);
        chk({tag, "_cnt_a"}, int'(cnt_a), CEN ? mcnt[0] : 0);
        chk({tag, "_cnt_b"}, int'(cnt_b), CEN ? mcnt[1] : 0);
        chk({tag, "_cnt_c"}, int'(cnt_c), CEN ? mcnt[2] : 0);
        chk({tag, "_cnt_d"}, int'(cnt_d), CEN ? mcnt[3] : 0);
    endtask

    task automatic cyc(input bit r, input bit c, input bit v, input logic b, input string tag);
        rst = r; clear = c; valid = v; in = b;
        @(posedge clk);
        model(r, c, v, (b === 1'b1));
        #1;
        compare(tag);
    endtask

    initial begin
        cyc(1, 0, 0, 1'b0, "reset");
        chk("reset_out_a", int'(out_a), 0);
        chk("reset_cnt_a", int'(cnt_a), 0);

        // 1,0,1,0,1 overlapping vs non-overlapping
        cyc(0, 0, 1, 1'b1, "s029");
        cyc(0, 0, 1, 1'b0, "s029");
        cyc(0, 0, 1, 1'b1, "s029");
        chk("bit3_out_a", int'(out_a), 1);
        chk("bit3_out_b", int'(out_b), 1);
        cyc(0, 0, 1, 1'b0, "s029");
        chk("bit4_out_a", int'(out_a), 0);
        cyc(0, 0, 1, 1'b1, "s029");
        chk("ovl_out", int'(out_a), 1);
        chk("ovl_cnt", int'(cnt_a), CEN ? 2 : 0);
        chk("novl_out", int'(out_b), 0);
        chk("novl_cnt", int'(cnt_b), CEN ? 1 : 0);

        // valid gap holds partial match
        cyc(1, 0, 0, 1'b0, "rst");
        cyc(0, 0, 1, 1'b1, "gap");
        cyc(0, 0, 1, 1'b0, "gap");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1'b1, "gap_hold");
        chk("gap_mid_out", int'(out_a), 0);
        cyc(0, 0, 1, 1'b1, "gap");
        chk("gap_out", int'(out_a), 1);
        cyc(0, 0, 0, 1'b0, "gap_stay");
        chk("gap_stay_out", int'(out_a), 1);
        chk("gap_cnt", int'(cnt_a), CEN ? 1 : 0);

        // saturation on 2-bit counter, pattern 11
        cyc(1, 0, 0, 1'b0, "rst");
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1'b1, "sat");
        chk("sat_out", int'(out_c), 1);
        chk("sat_cnt", int'(cnt_c), CEN ? 3 : 0);

        // reset mid-pattern discards the partial match
        cyc(1, 0, 0, 1'b0, "rst");
        cyc(0, 0, 1, 1'b1, "midrst");
        cyc(0, 0, 1, 1'b0, "midrst");
        cyc(1, 0, 1, 1'b1, "midrst");
        cyc(0, 0, 1, 1'b1, "midrst");
        chk("midrst_out", int'(out_a), 0);
        cyc(0, 0, 1, 1'b1, "midrst");
        cyc(0, 0, 1, 1'b0, "midrst");
        cyc(0, 0, 1, 1'b1, "midrst");
        chk("midrst_after_out", int'(out_a), 1);

        // clear discards the final bit; X input counts as 0
        cyc(1, 0, 0, 1'b0, "rst");
        cyc(0, 0, 1, 1'b1, "clr");
        cyc(0, 0, 1, 1'b0, "clr");
        cyc(0, 1, 1, 1'b1, "clr");
        chk("clr_out", int'(out_a), 0);
        chk("clr_cnt", int'(cnt_a), 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 1'bx, "xin");
            chk("xin_out", int'(out_a), 0);
        end

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(199, 0) == 0),
                ($urandom_range(99, 0) < 2),
                ($urandom_range(99, 0) < 75),
                logic'($urandom_range(1, 0)),
                "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
